// File: rtl/cp0_pkg.sv
// Shared CPU definitions: CP0 register numbers, field positions, exception codes
// and the handler address used by both cp0 and pc.
package cpu_defs;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int SR_IM_HI     = 15;
    localparam int SR_IM_LO     = 10;
    localparam int SR_EXL       = 1;
    localparam int SR_IE        = 0;
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_EXC_LO = 2;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    // Only the implemented fields are stored; everything else reads as zero.
    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc_code;
    } cause_t;

    function automatic logic [31:0] sr_word(input sr_t sr);
        logic [31:0] w;
        w                    = '0;
        w[SR_IM_HI:SR_IM_LO] = sr.im;
        w[SR_EXL]            = sr.exl;
        w[SR_IE]             = sr.ie;
        return w;
    endfunction

    function automatic logic [31:0] cause_word(input cause_t cause);
        logic [31:0] w;
        w                            = '0;
        w[CAUSE_BD]                  = cause.bd;
        w[CAUSE_IP_HI:CAUSE_IP_LO]   = cause.ip;
        w[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause.exc_code;
        return w;
    endfunction

endpackage

// File: rtl/cp0_if.sv
// Pipeline-to-CP0 bundle: M-stage mfc0/mtc0 traffic, victim info and interrupt lines,
// plus the request/EPC/read-data returned to the pipeline.
interface cp0_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    modport master (
        output A1, A2, DIn, We, PC, BD, ExcCode, HWInt, EXLClr,
        input  IntReq, EPC, DOut
    );

    modport slave (
        input  A1, A2, DIn, We, PC, BD, ExcCode, HWInt, EXLClr,
        output IntReq, EPC, DOut
    );
endinterface

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PrID, interrupt-vs-exception arbitration and
// M-stage mfc0/mtc0 service. Drives the PC's IRQ and supplies EPC for eret.
module cp0
    import cpu_defs::*;
#(
    parameter logic [31:0] PRID = 32'h2016_1115
) (
    input  logic  clk,
    input  logic  reset,
    cp0_if.slave  bus
);

    sr_t         sr_q,    sr_d;
    cause_t      cause_q, cause_d;
    logic [31:0] epc_q,   epc_d;

    logic        int_pend;
    logic        exc_pend;
    logic        int_req;
    logic [31:0] victim_pc;

    // Live HWInt feeds the request, not the registered Cause.IP copy.
    always_comb begin
        int_pend  = (|(bus.HWInt & sr_q.im)) & sr_q.ie & ~sr_q.exl;
        exc_pend  = (bus.ExcCode != EXC_INT) & ~sr_q.exl;
        int_req   = ~reset & (int_pend | exc_pend);
        victim_pc = bus.BD ? (bus.PC - 32'd4) : bus.PC;
    end

    // NOTE: every always_comb output gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        sr_d        = sr_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        cause_d.ip  = bus.HWInt;

        if (int_req) begin
            // Entry wins outright: a concurrent mtc0 is discarded.
            sr_d.exl         = 1'b1;
            cause_d.bd       = bus.BD;
            cause_d.exc_code = int_pend ? EXC_INT : bus.ExcCode;
            epc_d            = {victim_pc[31:2], 2'b00};
        end else begin
            if (bus.We) begin
                case (bus.A2)
                    REG_SR: begin
                        sr_d.im  = bus.DIn[SR_IM_HI:SR_IM_LO];
                        sr_d.exl = bus.DIn[SR_EXL];
                        sr_d.ie  = bus.DIn[SR_IE];
                    end
                    REG_EPC: epc_d = {bus.DIn[31:2], 2'b00};
                    default: ;
                endcase
            end
            // eret is applied after the write so it always leaves EXL clear.
            if (bus.EXLClr) sr_d.exl = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and outranks everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q    <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            sr_q    <= sr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    // Reads see committed state only; a same-cycle mtc0 is not bypassed.
    always_comb begin
        bus.DOut = '0;
        case (bus.A1)
            REG_SR:    bus.DOut = sr_word(sr_q);
            REG_CAUSE: bus.DOut = cause_word(cause_q);
            REG_EPC:   bus.DOut = epc_q;
            REG_PRID:  bus.DOut = PRID;
            default:   bus.DOut = '0;
        endcase
    end

    assign bus.IntReq = int_req;
    assign bus.EPC    = epc_q;

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios followed by randomized traffic
// compared against a word-level reference model of the CP0 registers.
module tb_cp0;
    import cpu_defs::*;

    localparam logic [31:0] PRID = 32'h2016_1115;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cp0_if bus ();

    cp0 #(.PRID(PRID)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state kept as architectural 32-bit words.
    logic [31:0] m_sr, m_cause, m_epc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_int_pend();
        return (|(bus.HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic model_req();
        if (reset) return 1'b0;
        return model_int_pend() || ((bus.ExcCode != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_update();
        logic req, ipend;
        logic [31:0] vpc;
        req   = model_req();
        ipend = model_int_pend();
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
            return;
        end
        if (req) begin
            m_sr[1] = 1'b1;
            m_cause = bus.BD ? 32'h8000_0000 : 32'h0;
            if (!ipend) m_cause = m_cause | ({27'd0, bus.ExcCode} << 2);
            vpc     = bus.BD ? bus.PC - 32'd4 : bus.PC;
            m_epc   = vpc & 32'hFFFF_FFFC;
        end else begin
            if (bus.We && bus.A2 == 5'd12) m_sr  = bus.DIn & 32'h0000_FC03;
            if (bus.We && bus.A2 == 5'd14) m_epc = bus.DIn & 32'hFFFF_FFFC;
            if (bus.EXLClr) m_sr[1] = 1'b0;
        end
        m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, bus.HWInt} << 10);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        bus.A1 = 0; bus.A2 = 0; bus.DIn = 0; bus.We = 0; bus.PC = 0;
        bus.BD = 0; bus.ExcCode = 0; bus.HWInt = 0; bus.EXLClr = 0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.A1 = a;
        #1;
        check(tag, bus.DOut, exp);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick(); tick();
        #1 check("irq_in_reset", 32'(bus.IntReq), 32'h0);
        reset = 1'b0;

        // Reset state
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        tick();
        rd("rst_prid", 5'd15, PRID);
        check("rst_irq", 32'(bus.IntReq), 32'h0);

        // mtc0/mfc0 on SR; unused bits dropped
        bus.We = 1; bus.A2 = 5'd12; bus.DIn = 32'hFFFF_FC03;
        tick();
        bus.We = 0;
        rd("sr_wr1", 5'd12, 32'h0000_FC03);
        bus.We = 1; bus.DIn = 32'h0000_FC01;
        tick();
        bus.We = 0;
        rd("sr_wr2", 5'd12, 32'h0000_FC01);

        // Interrupt entry
        bus.HWInt = 6'b000001; bus.PC = 32'h0000_3010; bus.BD = 0;
        #1 check("int_irq", 32'(bus.IntReq), 32'h1);
        tick();
        rd("int_sr", 5'd12, 32'h0000_FC03);
        rd("int_cause", 5'd13, 32'h0000_0400);
        check("int_epc", bus.EPC, 32'h0000_3010);
        check("int_irq_off", 32'(bus.IntReq), 32'h0);

        // eret plus write SR=0, then exception in a delay slot
        bus.HWInt = 0; bus.EXLClr = 1; bus.We = 1; bus.A2 = 5'd12; bus.DIn = 32'h0;
        tick();
        bus.EXLClr = 0; bus.We = 0;
        bus.ExcCode = EXC_OV; bus.PC = 32'h0000_3024; bus.BD = 1;
        #1 check("exc_irq", 32'(bus.IntReq), 32'h1);
        tick();
        idle();
        rd("exc_epc", 5'd14, 32'h0000_3020);
        rd("exc_cause", 5'd13, 32'h8000_0030);
        rd("exc_sr", 5'd12, 32'h0000_0002);

        // Priority and mtc0 drop on entry
        bus.We = 1; bus.A2 = 5'd12; bus.DIn = 32'h0000_FC01; bus.EXLClr = 1;
        tick();
        bus.EXLClr = 0;
        bus.HWInt = 6'b000100; bus.ExcCode = EXC_RI;
        bus.We = 1; bus.A2 = 5'd14; bus.DIn = 32'h1234_5678; bus.PC = 32'h0000_5008;
        #1 check("prio_irq", 32'(bus.IntReq), 32'h1);
        tick();
        bus.We = 0; bus.ExcCode = 0;
        rd("prio_cause", 5'd13, 32'h0000_1000);
        check("prio_epc", bus.EPC, 32'h0000_5008);

        // Nesting blocked while EXL=1
        bus.HWInt = 6'b111111; bus.ExcCode = EXC_ADEL;
        #1 check("nest_irq", 32'(bus.IntReq), 32'h0);
        tick();
        bus.ExcCode = 0;
        rd("nest_cause", 5'd13, 32'h0000_FC00);

        // eret: pending HWInt fires the following cycle
        bus.EXLClr = 1;
        #1 check("eret_irq0", 32'(bus.IntReq), 32'h0);
        tick();
        bus.EXLClr = 0;
        #1 check("eret_irq1", 32'(bus.IntReq), 32'h1);
        rd("eret_sr", 5'd12, 32'h0000_FC01);

        // Reset mid-handler
        tick();
        reset = 1; tick(); reset = 0;
        rd("rst2_sr", 5'd12, 32'h0);
        check("rst2_irq", 32'(bus.IntReq), 32'h0);

        // PC-4 wraps modulo 2^32
        bus.HWInt = 0; bus.ExcCode = EXC_ADES; bus.PC = 32'h0000_0002; bus.BD = 1;
        tick();
        idle();
        rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset       = ($urandom_range(0, 99) == 0);
            bus.A1      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            bus.A2      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            bus.DIn     = $urandom;
            bus.We      = ($urandom_range(0, 3) == 0);
            bus.PC      = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            bus.BD      = 1'($urandom);
            bus.ExcCode = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            bus.HWInt   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            bus.EXLClr  = ($urandom_range(0, 5) == 0);
            #1;
            check("rnd_irq", 32'(bus.IntReq), 32'(model_req()));
            check("rnd_epc", bus.EPC, m_epc);
            check("rnd_dout", bus.DOut, model_read(bus.A1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
